reg_file: RTL

// - RV32 integer register file: 2 combinational read ports, 1 write port, plus a busy-bit scoreboard.
// - Read-side complement of the writeback path built from `register`.
// - Sits between decode (reads, issue) and writeback.
// - Busy bits track pending long-latency results (load, mul); stall_o holds decode until those operands land.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/reg_file_scoreboard.sv | 89 ++++++++
 rtl/reg_file.sv | 106 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32 integer register file and its scoreboard.
//   reg_idx_t : architectural register index (x0..x31)
//   NUM_REGS  : default number of architectural registers
//   ZERO_REG  : index of the hardwired-zero register
//   idx_live  : true when an index names a real, writable register
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam int       NUM_REGS = 32;
    localparam reg_idx_t ZERO_REG = '0;

    // A register index is "live" when it is neither x0 nor beyond the end of
    // the register array. Used to drop writes and bypasses that must not land.
    function automatic logic idx_live(input int idx, input int num_regs);
        return (idx != int'(ZERO_REG)) && (idx < num_regs);
    endfunction

endpackage : riscv_pkg

// File: rtl/reg_file_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_file_scoreboard
// Busy-bit scoreboard for long-latency results (loads, multiplies).
// A busy bit is set when decode issues a producer for that register and is
// cleared when writeback delivers the value. stall_o holds decode while a
// consumed source is still pending and is not being written this cycle.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   rs1_addr_i    source 1 index       rs1_used_i  decode consumes source 1
//   rs2_addr_i    source 2 index       rs2_used_i  decode consumes source 2
//   wr_en_i       writeback enable     wr_addr_i   writeback index
//   issue_en_i    long-latency issue   issue_rd_i  destination of that issue
//   stall_o       hold decode
// -----------------------------------------------------------------------------
module reg_file_scoreboard #(
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic              rs1_used_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    input  logic              rs2_used_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic              stall_o
);

    import riscv_pkg::*;

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                rs1_wait;
    logic                rs2_wait;

    // Busy lookup by full-width compare; x0 and out-of-range indices never
    // match, so they read as not busy.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] vec,
                                     input logic [ADDR_W-1:0]   idx);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (idx == ADDR_W'(i)) hit = vec[i];
        end
        return hit;
    endfunction

    // A pending source that is being written back this very cycle is
    // resolved through the read bypass, so it does not stall.
    always_comb begin
        rs1_wait = rs1_used_i && busy_at(busy_q, rs1_addr_i)
                   && !(wr_en_i && (wr_addr_i == rs1_addr_i));
        rs2_wait = rs2_used_i && busy_at(busy_q, rs2_addr_i)
                   && !(wr_en_i && (wr_addr_i == rs2_addr_i));
        stall_o  = !rst && (rs1_wait || rs2_wait);
    end

    // NOTE: every always_comb output gets a full default before any
    // conditional update; a path that leaves it unassigned infers a latch.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            // Evaluated after the clear: a newly issued producer supersedes
            // the result landing now. Issues under stall are not real issues.
            if (issue_en_i && !stall_o && (issue_rd_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[int'(ZERO_REG)] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule : reg_file_scoreboard

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
// RV32 integer register file: two combinational read ports, one write port
// with same-cycle write-to-read bypass, and a busy-bit scoreboard that stalls
// decode on operands still owed by long-latency units.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   rs1_addr / rs1_data      read port 1 (combinational)
//   rs2_addr / rs2_data      read port 2 (combinational)
//   rs1_used, rs2_used       decode consumes that source (gates stall)
//   wr_en, wr_addr, wr_data  writeback port
//   issue_en, issue_rd       long-latency issue and its destination
//   stall                    a used source is pending and not landing now
//
// x0 reads as zero and ignores writes. When NUM_REGS is not a power of two,
// indices past the end read as zero and their writes/issues are dropped.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [WIDTH-1:0]  rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [WIDTH-1:0]  rs2_data,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              stall
);

    import riscv_pkg::*;

    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] regs_d [NUM_REGS];
    logic             wr_live;

    // A write only lands (and only bypasses) when it targets a real register.
    assign wr_live = wr_en && idx_live(int'(wr_addr), NUM_REGS);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (wr_live && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
        end
        regs_d[int'(ZERO_REG)] = '0;
    end

    // NOTE: the array is cleared on reset because architectural state must be
    // zero after reset; this costs a reset pin per bit, unlike a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes: start from zero so x0 and out-of-range indices read 0, then
    // let an in-flight writeback override the stored value.
    always_comb begin
        rs1_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs1_addr == ADDR_W'(i)) rs1_data = regs_q[i];
        end
        if (wr_live && (wr_addr == rs1_addr)) rs1_data = wr_data;
    end

    always_comb begin
        rs2_data = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rs2_addr == ADDR_W'(i)) rs2_data = regs_q[i];
        end
        if (wr_live && (wr_addr == rs2_addr)) rs2_data = wr_data;
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (rs1_addr),
        .rs1_used_i (rs1_used),
        .rs2_addr_i (rs2_addr),
        .rs2_used_i (rs2_used),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .issue_en_i (issue_en),
        .issue_rd_i (issue_rd),
        .stall_o    (stall)
    );

endmodule : reg_file
